// File: rtl/zigbee_cordic_pipe.sv
// zigbee_cordic_pipe
//
// Fully pipelined CORDIC engine for the Zigbee demodulator.
//   mode_in = 0 (vectoring): (x, y, w) -> (K*|x+jy|, ~0, w + atan2(y, x))
//   mode_in = 1 (rotation) : (x, y, w) -> K * (x + jy) * e^(jw), w -> ~0
// A registered quadrant pre-rotation stage extends coverage to the full
// +/-pi range. It is followed by NB_STAGES registered micro-rotations.
// Latency is NB_STAGES+1 enabled cycles and throughput is one sample per
// enabled cycle. The gain K (about 1.6468) is not compensated.
//
// Ports:
//   clk       rising-edge clock
//   resetb    asynchronous active-low reset; clears every pipeline register
//   en        clock enable; 0 holds every register, including valid/outputs
//   mode_in   0 = vectoring, 1 = rotation (travels with the sample)
//   xin/yin   signed XY_SIZE-bit input vector
//   win       signed W_SIZE-bit phase (+/-pi = +/-2^(W_SIZE-1))
//   validIn   input sample valid
//   xout/yout signed XY_SIZE+2-bit result vector
//   wout      signed W_SIZE-bit result phase (wraps modulo 2^W_SIZE)
//   mode_out  mode of the sample on the outputs
//   validOut  result valid
//
// Handshake: valid-only streaming with no backpressure. A sample is accepted
// on every rising edge where en=1 and validIn=1. A result is presented
// whenever validOut=1. en=0 stalls the whole pipeline in place. Data
// registers load on every enabled edge regardless of valid, so output data
// is meaningful only while validOut=1.

module zigbee_cordic_pipe #(
  parameter int NB_STAGES = 12,
  parameter int XY_SIZE   = 12,
  parameter int W_SIZE    = 16
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      en,
  input  logic                      mode_in,
  input  logic signed [XY_SIZE-1:0] xin,
  input  logic signed [XY_SIZE-1:0] yin,
  input  logic signed [W_SIZE-1:0]  win,
  input  logic                      validIn,
  output logic signed [XY_SIZE+1:0] xout,
  output logic signed [XY_SIZE+1:0] yout,
  output logic signed [W_SIZE-1:0]  wout,
  output logic                      mode_out,
  output logic                      validOut
);

  localparam int  XW   = XY_SIZE + 2;
  localparam real PI_R = 3.14159265358979323846;

  localparam logic signed [W_SIZE-1:0] HALF_PI     = W_SIZE'(1 << (W_SIZE - 2));
  localparam logic signed [W_SIZE-1:0] NEG_HALF_PI = -HALF_PI;

  // atan(2^-i) scaled so that pi maps to 2^(W_SIZE-1), rounded to nearest.
  function automatic int atan_code(input int i);
    real r;
    r = $atan(1.0 / real'(1 << i)) * real'(1 << (W_SIZE - 1)) / PI_R;
    return int'(r);
  endfunction

  logic signed [W_SIZE-1:0] atan_tab [NB_STAGES];

  for (genvar g = 0; g < NB_STAGES; g++) begin : g_atan
    localparam int ATAN_VAL = atan_code(g);
    assign atan_tab[g] = W_SIZE'(ATAN_VAL);
  end

  // Pipeline registers. Index 0 holds the pre-rotation result and index i+1
  // holds the output of micro-rotation i, so index NB_STAGES drives the ports.
  logic signed [XW-1:0]     x_q     [NB_STAGES+1];
  logic signed [XW-1:0]     y_q     [NB_STAGES+1];
  logic signed [W_SIZE-1:0] w_q     [NB_STAGES+1];
  logic                     mode_q  [NB_STAGES+1];
  logic                     valid_q [NB_STAGES+1];

  // Quadrant pre-rotation. Inputs are sign-extended by two guard bits, so
  // negating the most negative input code cannot overflow.
  logic signed [XW-1:0]     xin_ext, yin_ext;
  logic signed [XW-1:0]     pre_x, pre_y;
  logic signed [W_SIZE-1:0] pre_w;

  assign xin_ext = {{2{xin[XY_SIZE-1]}}, xin};
  assign yin_ext = {{2{yin[XY_SIZE-1]}}, yin};

  always_comb begin
    pre_x = xin_ext;
    pre_y = yin_ext;
    pre_w = win;
    if (!mode_in) begin
      // Vectoring: fold the left half-plane into the right half-plane.
      if (xin[XY_SIZE-1]) begin
        if (!yin[XY_SIZE-1]) begin
          pre_x = yin_ext;
          pre_y = -xin_ext;
          pre_w = win + HALF_PI;
        end else begin
          pre_x = -yin_ext;
          pre_y = xin_ext;
          pre_w = win - HALF_PI;
        end
      end
    end else begin
      // Rotation: bring the angle into [-pi/2, pi/2] with a quarter turn.
      if (win > HALF_PI) begin
        pre_x = -yin_ext;
        pre_y = xin_ext;
        pre_w = win - HALF_PI;
      end else if (win < NEG_HALF_PI) begin
        pre_x = yin_ext;
        pre_y = -xin_ext;
        pre_w = win + HALF_PI;
      end
    end
  end

  // Per-stage direction. Vectoring with y<0 and rotation with w>=0 both call
  // for the same update: x -= y>>>i, y += x>>>i, w -= atan.
  logic [NB_STAGES-1:0] ccw;

  always_comb begin
    ccw = '0;
    for (int i = 0; i < NB_STAGES; i++) begin
      ccw[i] = mode_q[i] ? ~w_q[i][W_SIZE-1] : y_q[i][XW-1];
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i <= NB_STAGES; i++) begin
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        w_q[i]     <= '0;
        mode_q[i]  <= 1'b0;
        valid_q[i] <= 1'b0;
      end
    end else if (en) begin
      x_q[0]     <= pre_x;
      y_q[0]     <= pre_y;
      w_q[0]     <= pre_w;
      mode_q[0]  <= mode_in;
      valid_q[0] <= validIn;
      for (int i = 0; i < NB_STAGES; i++) begin
        // Both updates use the pre-update x and y of stage i.
        if (ccw[i]) begin
          x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
          w_q[i+1] <= w_q[i] - atan_tab[i];
        end else begin
          x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
          y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
          w_q[i+1] <= w_q[i] + atan_tab[i];
        end
        mode_q[i+1]  <= mode_q[i];
        valid_q[i+1] <= valid_q[i];
      end
    end
  end

  assign xout     = x_q[NB_STAGES];
  assign yout     = y_q[NB_STAGES];
  assign wout     = w_q[NB_STAGES];
  assign mode_out = mode_q[NB_STAGES];
  assign validOut = valid_q[NB_STAGES];

endmodule

// File: tb/tb_zigbee_cordic_pipe.sv
// tb_zigbee_cordic_pipe
//
// Bench for zigbee_cordic_pipe (NB_STAGES=12, XY_SIZE=12, W_SIZE=16).
// Expected results come from an ideal floating-point CORDIC model: gain K
// times the exact magnitude/rotation, with exact atan2 phase. They are pushed
// to queues when a sample is driven, and a monitor pops and compares them
// whenever a new result appears. Tolerances are +/-3 LSB on x/y and +/-8 LSB
// on w, with the phase difference taken modulo 2^16.

module tb_zigbee_cordic_pipe;

  localparam int  NB   = 12;
  localparam int  XY   = 12;
  localparam int  W    = 16;
  localparam int  XW   = XY + 2;
  localparam real PI   = 3.14159265358979323846;
  localparam int  TOL_XY = 3;
  localparam int  TOL_W  = 8;

  logic                 clk = 1'b0;
  logic                 resetb = 1'b0;
  logic                 en = 1'b1;
  logic                 mode_in = 1'b0;
  logic signed [XY-1:0] xin = '0;
  logic signed [XY-1:0] yin = '0;
  logic signed [W-1:0]  win = '0;
  logic                 validIn = 1'b0;
  logic signed [XW-1:0] xout;
  logic signed [XW-1:0] yout;
  logic signed [W-1:0]  wout;
  logic                 mode_out;
  logic                 validOut;

  zigbee_cordic_pipe #(.NB_STAGES(NB), .XY_SIZE(XY), .W_SIZE(W)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .en       (en),
    .mode_in  (mode_in),
    .xin      (xin),
    .yin      (yin),
    .win      (win),
    .validIn  (validIn),
    .xout     (xout),
    .yout     (yout),
    .wout     (wout),
    .mode_out (mode_out),
    .validOut (validOut)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard ----------------
  logic signed [31:0] exp_x_q[$];
  logic signed [31:0] exp_y_q[$];
  logic signed [31:0] exp_w_q[$];
  logic               exp_m_q[$];

  real k_gain;
  initial begin
    k_gain = 1.0;
    for (int i = 0; i < NB; i++) k_gain = k_gain * $sqrt(1.0 + 1.0 / real'(1 << (2 * i)));
  end

  // en as seen by the DUT at the last rising edge: a new result exists only
  // when that edge was enabled.
  logic en_at_edge = 1'b0;
  always @(posedge clk) en_at_edge <= en;

  always @(negedge clk) begin
    if (resetb && validOut && en_at_edge) begin
      if (exp_x_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got x=%0d y=%0d w=%0d with no sample pending", xout, yout, wout);
      end else begin
        int ex, ey, ew, dx, dy, dwi;
        logic em;
        logic signed [W-1:0] dw16;
        ex = exp_x_q.pop_front();
        ey = exp_y_q.pop_front();
        ew = exp_w_q.pop_front();
        em = exp_m_q.pop_front();
        dx = int'(xout) - ex;
        dy = int'(yout) - ey;
        dw16 = W'(int'(wout) - ew);
        dwi = int'(dw16);
        checks++;
        if (dx > TOL_XY || dx < -TOL_XY) begin
          errors++;
          $display("FAIL xout got %0d want %0d +/-%0d (mode %0d)", xout, ex, TOL_XY, em);
        end
        checks++;
        if (dy > TOL_XY || dy < -TOL_XY) begin
          errors++;
          $display("FAIL yout got %0d want %0d +/-%0d (mode %0d)", yout, ey, TOL_XY, em);
        end
        checks++;
        if (dwi > TOL_W || dwi < -TOL_W) begin
          errors++;
          $display("FAIL wout got %0d want %0d +/-%0d mod 2^16 (mode %0d)", wout, ew, TOL_W, em);
        end
        checks++;
        if (mode_out !== em) begin
          errors++;
          $display("FAIL mode_out got %0b want %0b", mode_out, em);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input logic m, input int x, input int y, input int w);
    real a, ex, ey;
    int  ew;
    if (!m) begin
      ex = k_gain * $sqrt(real'(x * x + y * y));
      ey = 0.0;
      ew = w + int'($atan2(real'(y), real'(x)) * 32768.0 / PI);
    end else begin
      a  = real'(w) * PI / 32768.0;
      ex = k_gain * (real'(x) * $cos(a) - real'(y) * $sin(a));
      ey = k_gain * (real'(x) * $sin(a) + real'(y) * $cos(a));
      ew = 0;
    end
    exp_x_q.push_back(int'(ex));
    exp_y_q.push_back(int'(ey));
    exp_w_q.push_back(ew);
    exp_m_q.push_back(m);
  endtask

  // Called at a falling edge; drives one valid sample for the next rising edge.
  task automatic send(input logic m, input int x, input int y, input int w);
    mode_in = m;
    xin     = XY'(x);
    yin     = XY'(y);
    win     = W'(w);
    validIn = 1'b1;
    if (en) push_expected(m, x, y, w);
    @(negedge clk);
  endtask

  // Directed sample table: four vectoring cases and two rotation cases.
  int vec_x [4] = '{1000, 0, -1000, -1000};
  int vec_y [4] = '{0, 1000, 0, -1000};
  int rot_w [2] = '{8192, -24576};

  task automatic send_mixed(input int k);
    if (k % 2 == 0) send(1'b0, vec_x[(k / 2) % 4], vec_y[(k / 2) % 4], 0);
    else            send(1'b1, 1000, 0, rot_w[(k / 2) % 2]);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (exp_x_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    resetb  = 1'b0;
    en      = 1'b1;
    validIn = 1'b1;
    mode_in = 1'b1;
    xin     = XY'($urandom_range(1, 2047));
    yin     = XY'($urandom_range(1, 2047));
    win     = W'($urandom_range(1, 16000));
    repeat (4) @(negedge clk);
    checks++; if (xout !== '0)     begin errors++; $display("FAIL reset_xout got %0d want 0", xout); end
    checks++; if (yout !== '0)     begin errors++; $display("FAIL reset_yout got %0d want 0", yout); end
    checks++; if (wout !== '0)     begin errors++; $display("FAIL reset_wout got %0d want 0", wout); end
    checks++; if (mode_out !== 0)  begin errors++; $display("FAIL reset_mode_out got %0b want 0", mode_out); end
    checks++; if (validOut !== 0)  begin errors++; $display("FAIL reset_validOut got %0b want 0", validOut); end
    validIn = 1'b0;
    resetb  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency;
    int hits;
    bit ok;
    hits = 0;
    send(1'b0, 1000, 0, 0);
    validIn = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      if (validOut !== (k == NB + 1)) begin
        errors++;
        $display("FAIL latency_cycle_%0d validOut got %0b want %0b", k, validOut, (k == NB + 1));
      end
      if (validOut === 1'b1) hits++;
    end
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL latency_pulse_count got %0d want 1", hits);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL latency_drain got %0d pending want 0", exp_x_q.size()); end
  endtask

  task automatic test_vectoring;
    bit ok;
    for (int k = 0; k < 4; k++) send(1'b0, vec_x[k], vec_y[k], 0);
    send(1'b0, 600, -300, 4000);
    validIn = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL vectoring_drain got %0d pending want 0", exp_x_q.size()); end
  endtask

  task automatic test_rotation;
    bit ok;
    for (int k = 0; k < 2; k++) send(1'b1, 1000, 0, rot_w[k]);
    send(1'b1, 1000, 0, 16384);
    validIn = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rotation_drain got %0d pending want 0", exp_x_q.size()); end
  endtask

  task automatic test_back_to_back;
    int run;
    bit ok;
    run = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) send_mixed(k);
        validIn = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && validOut !== 1'b1; c++) @(negedge clk);
        while (validOut === 1'b1 && run < 30) begin
          run++;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (run != 20) begin errors++; $display("FAIL back_to_back_run got %0d want 20", run); end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL back_to_back_drain got %0d pending want 0", exp_x_q.size()); end
  endtask

  task automatic test_stall;
    logic [2*XW+W+1:0] snap;
    bit ok;
    for (int k = 0; k < 20; k++) begin
      if (k == 16) begin
        en = 1'b0;
        snap = {xout, yout, wout, mode_out, validOut};
        for (int s = 0; s < 5; s++) begin
          mode_in = 1'($urandom_range(0, 1));
          xin     = XY'($urandom_range(0, 4095));
          yin     = XY'($urandom_range(0, 4095));
          win     = W'($urandom_range(0, 65535));
          validIn = 1'b1;
          @(negedge clk);
          checks++;
          if ({xout, yout, wout, mode_out, validOut} !== snap) begin
            errors++;
            $display("FAIL stall_frozen_%0d got %h want %h", s, {xout, yout, wout, mode_out, validOut}, snap);
          end
        end
        en = 1'b1;
      end
      send_mixed(k);
    end
    validIn = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_drain got %0d pending want 0", exp_x_q.size()); end
  endtask

  task automatic test_reset_mid;
    int stale;
    bit ok;
    stale = 0;
    for (int k = 0; k < 16; k++) send_mixed(k);
    resetb  = 1'b0;
    validIn = 1'b0;
    #1;
    checks++;
    if (validOut !== 1'b0 || xout !== '0) begin
      errors++;
      $display("FAIL reset_mid_immediate got validOut=%0b xout=%0d want 0 0", validOut, xout);
    end
    exp_x_q.delete();
    exp_y_q.delete();
    exp_w_q.delete();
    exp_m_q.delete();
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (validOut === 1'b1) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL reset_mid_stale got %0d valid cycles want 0", stale); end
    send(1'b0, -1000, -1000, 0);
    validIn = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_mid_recover got %0d pending want 0", exp_x_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_vectoring();
    test_rotation();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_x_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue got %0d pending want 0", exp_x_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
